// File: rtl/sync_fifo_flex.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_flex
//  Brief    : Parametrised single-clock FIFO with occupancy count,
//             almost-full/almost-empty flags, synchronous flush, error pulses
//             and selectable standard / first-word-fall-through read mode.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_flex #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   rvalid_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   almost_full_o,
    output logic                   almost_empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   wr_error_o,
    output logic                   rd_error_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = c_AW + 1;
    localparam logic [c_PW-1:0] c_DEPTH  = c_PW'(DEPTH);
    localparam logic [c_PW-1:0] c_AFULL  = c_PW'(AFULL_TH);
    localparam logic [c_PW-1:0] c_AEMPTY = c_PW'(AEMPTY_TH);
    localparam logic [c_PW-1:0] c_ONE    = c_PW'(1);

    // Elaboration-time parameter sanity checks
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_flex: DEPTH must be a power of two >= 2");
    end
    if ((AFULL_TH < 1) || (AFULL_TH > DEPTH)) begin : g_bad_afull
        $error("sync_fifo_flex: AFULL_TH out of range 1..DEPTH");
    end
    if ((AEMPTY_TH < 0) || (AEMPTY_TH > DEPTH - 1)) begin : g_bad_aempty
        $error("sync_fifo_flex: AEMPTY_TH out of range 0..DEPTH-1");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_PW-1:0]  r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_afull;
    logic             r_aempty;
    logic             r_wr_err;
    logic             r_rd_err;
    logic [WIDTH-1:0] r_rdata;

    logic             w_rd_acc;
    logic             w_wr_acc;
    logic [c_PW-1:0]  w_wr_ptr_nxt;
    logic [c_PW-1:0]  w_rd_ptr_nxt;
    logic [c_PW-1:0]  w_count_nxt;

    // Accept decisions and next pointer/count; flush overrides all traffic.
    // A write into a full FIFO is allowed when a read frees a slot this edge.
    always_comb begin
        w_rd_acc     = ~flush_i & rd_en_i & ~r_empty;
        w_wr_acc     = ~flush_i & wr_en_i & (~r_full | w_rd_acc);
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (flush_i) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end else begin
            if (w_wr_acc) begin
                w_wr_ptr_nxt = r_wr_ptr + c_ONE;
            end
            if (w_rd_acc) begin
                w_rd_ptr_nxt = r_rd_ptr + c_ONE;
            end
        end
        w_count_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
    end

    // Storage array: written on accepted writes only, never reset
    always_ff @(posedge clk_i) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= wdata_i;
        end
    end

    // Pointers, occupancy, status flags and error pulses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == c_DEPTH);
            r_empty  <= (w_count_nxt == '0);
            r_afull  <= (w_count_nxt >= c_AFULL);
            r_aempty <= (w_count_nxt <= c_AEMPTY);
            r_wr_err <= ~flush_i & wr_en_i & r_full & ~w_rd_acc;
            r_rd_err <= ~flush_i & rd_en_i & r_empty;
        end
    end

    if (FWFT != 0) begin : g_fwft
        logic [WIDTH-1:0] w_head;

        // Next head word; bypass write data when the word being written
        // becomes the head at this very edge (write into empty / drained FIFO)
        always_comb begin
            w_head = r_mem[w_rd_ptr_nxt[c_AW-1:0]];
            if (w_wr_acc && (w_rd_ptr_nxt == r_wr_ptr)) begin
                w_head = wdata_i;
            end
        end

        // Present the head word whenever the FIFO will hold data
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_rdata <= '0;
            end else if (w_count_nxt != '0) begin
                r_rdata <= w_head;
            end
        end

        assign rvalid_o = ~r_empty;
    end else begin : g_std
        logic r_rvalid;

        // Register the head word on an accepted read, hold otherwise
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_rdata  <= '0;
                r_rvalid <= 1'b0;
            end else begin
                r_rvalid <= w_rd_acc;
                if (w_rd_acc) begin
                    r_rdata <= r_mem[r_rd_ptr[c_AW-1:0]];
                end
            end
        end

        assign rvalid_o = r_rvalid;
    end

    assign rdata_o        = r_rdata;
    assign full_o         = r_full;
    assign empty_o        = r_empty;
    assign almost_full_o  = r_afull;
    assign almost_empty_o = r_aempty;
    assign count_o        = r_count;
    assign wr_error_o     = r_wr_err;
    assign rd_error_o     = r_rd_err;

endmodule
`default_nettype wire
